// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the unified-memory arbiter.
//   u32_t       : 32-bit address / data word
//   wrstb_t     : 4-bit byte write strobe (all zero means read)
//   arb_state_e : arbiter FSM state (what was issued last cycle)
//   arb_grant_e : combinational grant decision for the current cycle
package mem_arbiter_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;

    localparam wrstb_t WRSTB_READ = 4'b0000;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_RESP = 2'd1,
        ARB_D_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_grant_e;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk : clock, rising edge
//   clr : synchronous clear, has priority over inc
//   inc : count enable; the counter sticks at all-ones instead of wrapping
//   cnt : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous-read RAM between the instruction-fetch
// port (I) and the data port (D). Each requester raises req and holds its
// address/data until a one-cycle ack; read data is returned with the ack.
//
// Handshake: a requester asserts *_req with stable address (and, for D,
// write data/strobes) and keeps them until *_ack pulses. The access is
// granted combinationally in the cycle it becomes eligible, the memory is
// strobed that same cycle, and the ack (with read data) follows one cycle
// later. The requester must drop req the cycle after ack unless it is
// presenting a new request.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   i_req/i_addr             instruction read request
//   i_ack/i_rddata           instruction completion pulse + data
//   d_req/d_addr/d_wrdata/d_wrstb  data request (wrstb==0 is a read)
//   d_ack/d_rddata           data completion pulse + read data
//   mem_en/mem_addr/mem_wrdata/mem_wrstb  shared memory port
//   mem_rddata               memory read data, valid the cycle after a read
//   conflict_cnt             saturating count of cycles where both ports
//                            were eligible at once
//   state_dbg                current FSM state, for observation
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req,
    input  u32_t             i_addr,
    output logic             i_ack,
    output u32_t             i_rddata,

    input  logic             d_req,
    input  u32_t             d_addr,
    input  u32_t             d_wrdata,
    input  wrstb_t           d_wrstb,
    output logic             d_ack,
    output u32_t             d_rddata,

    output logic             mem_en,
    output u32_t             mem_addr,
    output u32_t             mem_wrdata,
    output wrstb_t           mem_wrstb,
    input  u32_t             mem_rddata,

    output logic [CNT_W-1:0] conflict_cnt,
    output arb_state_e       state_dbg
);

    arb_state_e state_q;
    arb_state_e state_d;
    arb_grant_e grant;
    logic       i_elig;
    logic       d_elig;

    // Last address/data driven to the memory; the port holds these when
    // nothing is granted so the bus does not toggle needlessly.
    u32_t       addr_q;
    u32_t       wrdata_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility, grant, next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        i_elig  = 1'b0;
        d_elig  = 1'b0;
        grant   = GNT_NONE;
        state_d = ARB_IDLE;
        i_ack   = 1'b0;
        d_ack   = 1'b0;

        // A port whose access is completing this cycle still has req high
        // for that access, so it must not be granted again yet.
        i_elig = i_req && (state_q != ARB_I_RESP);
        d_elig = d_req && (state_q != ARB_D_RESP);

        // D wins ties; I only goes when D is not eligible.
        if (d_elig) begin
            grant = GNT_D;
        end else if (i_elig) begin
            grant = GNT_I;
        end else begin
            grant = GNT_NONE;
        end

        unique case (grant)
            GNT_I:   state_d = ARB_I_RESP;
            GNT_D:   state_d = ARB_D_RESP;
            default: state_d = ARB_IDLE;
        endcase

        // Acks come from registered state; gating with rst drops an
        // in-flight access when reset lands on its response cycle.
        i_ack = (state_q == ARB_I_RESP) && !rst;
        d_ack = (state_q == ARB_D_RESP) && !rst;
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    always_comb begin
        mem_en     = 1'b0;
        mem_addr   = addr_q;
        mem_wrdata = wrdata_q;
        mem_wrstb  = WRSTB_READ;

        mem_en = (grant != GNT_NONE) && !rst;

        unique case (grant)
            GNT_D: begin
                mem_addr   = d_addr;
                mem_wrdata = d_wrdata;
                mem_wrstb  = rst ? WRSTB_READ : d_wrstb;
            end
            GNT_I: begin
                mem_addr  = i_addr;
                mem_wrstb = WRSTB_READ;
            end
            default: begin
                mem_addr   = addr_q;
                mem_wrdata = wrdata_q;
                mem_wrstb  = WRSTB_READ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wrdata_q <= '0;
        end else begin
            addr_q   <= mem_addr;
            wrdata_q <= mem_wrdata;
        end
    end

    // Read data goes straight through; it is only meaningful with the ack.
    assign i_rddata = mem_rddata;
    assign d_rddata = mem_rddata;

    assign state_dbg = state_q;

    // ------------------------------------------------------------------
    // Contention counter
    // ------------------------------------------------------------------
    sat_counter #(
        .W(CNT_W)
    ) u_conflict_cnt (
        .clk(clk),
        .clr(rst),
        .inc(i_elig && d_elig),
        .cnt(conflict_cnt)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of per-cycle vectors on the default-width
// instance backed by a small behavioural RAM, followed by hand-written
// sequences for reset during an access and counter saturation on a
// second instance with a 2-bit counter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------
  // DUT 0 (CNT_W = 16) signals
  // --------------------------------------------------------------------
  logic        i_req;
  u32_t        i_addr;
  logic        i_ack;
  u32_t        i_rddata;
  logic        d_req;
  u32_t        d_addr;
  u32_t        d_wrdata;
  wrstb_t      d_wrstb;
  logic        d_ack;
  u32_t        d_rddata;
  logic        mem_en;
  u32_t        mem_addr;
  u32_t        mem_wrdata;
  wrstb_t      mem_wrstb;
  u32_t        mem_rddata;
  logic [15:0] conflict_cnt;
  arb_state_e  state_dbg;

  mem_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rddata(i_rddata),
    .d_req(d_req), .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wrstb(d_wrstb),
    .d_ack(d_ack), .d_rddata(d_rddata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_wrstb(mem_wrstb), .mem_rddata(mem_rddata),
    .conflict_cnt(conflict_cnt), .state_dbg(state_dbg)
  );

  // --------------------------------------------------------------------
  // DUT 1 (CNT_W = 2) signals, used for saturation only
  // --------------------------------------------------------------------
  logic       i2_req;
  u32_t       i2_addr;
  logic       i2_ack;
  u32_t       i2_rddata;
  logic       d2_req;
  u32_t       d2_addr;
  u32_t       d2_wrdata;
  wrstb_t     d2_wrstb;
  logic       d2_ack;
  u32_t       d2_rddata;
  logic       mem2_en;
  u32_t       mem2_addr;
  u32_t       mem2_wrdata;
  wrstb_t     mem2_wrstb;
  u32_t       mem2_rddata;
  logic [1:0] conflict2_cnt;
  arb_state_e state2_dbg;

  mem_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_req(i2_req), .i_addr(i2_addr), .i_ack(i2_ack), .i_rddata(i2_rddata),
    .d_req(d2_req), .d_addr(d2_addr), .d_wrdata(d2_wrdata), .d_wrstb(d2_wrstb),
    .d_ack(d2_ack), .d_rddata(d2_rddata),
    .mem_en(mem2_en), .mem_addr(mem2_addr), .mem_wrdata(mem2_wrdata),
    .mem_wrstb(mem2_wrstb), .mem_rddata(mem2_rddata),
    .conflict_cnt(conflict2_cnt), .state_dbg(state2_dbg)
  );

  // --------------------------------------------------------------------
  // Behavioural synchronous-read RAM behind DUT 0 (256 words)
  // --------------------------------------------------------------------
  logic [31:0] ram [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wrstb == 4'b0000) begin
        mem_rddata <= ram[mem_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wrstb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wrdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       i_req;
    u32_t       i_addr;
    logic       d_req;
    u32_t       d_addr;
    u32_t       d_wrdata;
    wrstb_t     d_wrstb;
    logic       e_en;
    u32_t       e_addr;
    wrstb_t     e_wrstb;
    logic       e_iack;
    u32_t       e_idata;
    logic       e_dack;
    u32_t       e_ddata;
    logic       c_ddata;
    logic [15:0] e_cnt;
    arb_state_e e_state;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ir, input u32_t ia,
    input logic dr, input u32_t da, input u32_t dw, input wrstb_t ds,
    input logic en, input u32_t ea, input wrstb_t es,
    input logic ik, input u32_t id, input logic dk, input u32_t dd,
    input logic cd, input logic [15:0] cn, input arb_state_e st);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia;
    v.d_req = dr; v.d_addr = da; v.d_wrdata = dw; v.d_wrstb = ds;
    v.e_en = en; v.e_addr = ea; v.e_wrstb = es;
    v.e_iack = ik; v.e_idata = id; v.e_dack = dk; v.e_ddata = dd;
    v.c_ddata = cd; v.e_cnt = cn; v.e_state = st;
    return v;
  endfunction

  vec_t vecs [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  initial begin
    localparam u32_t WDATA = 32'h1122_3344;
    localparam u32_t MERGED = 32'hAABB_3344;

    for (int k = 0; k < 256; k++) ram[k] = 32'h0;
    ram[8'h40] = 32'hDEAD_BEEF;   // byte address 0x100
    ram[8'h80] = 32'hAABB_CCDD;   // byte address 0x200

    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_wrdata = 32'h0; d_wrstb = 4'b0000;
    i2_req = 1'b0; i2_addr = 32'h40; d2_req = 1'b0; d2_addr = 32'h80;
    d2_wrdata = 32'h0; d2_wrstb = 4'b0000; mem2_rddata = 32'h0;

    //                r  ir ia      dr da      dw     ds       en ea      es       ik id            dk dd            cd cnt state
    // reset with both requesting
    vecs[0]  = mk(1, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[1]  = mk(1, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    // single I read of 0x100
    vecs[2]  = mk(0, 1, 32'h100, 0, 32'h200, 0,     4'b0000, 1, 32'h100, 4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[3]  = mk(0, 1, 32'h100, 0, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 1, 32'hDEADBEEF, 0, 0,            0, 0, ARB_I_RESP);
    // D write of the low halfword at 0x200
    vecs[4]  = mk(0, 0, 32'h100, 1, 32'h200, WDATA, 4'b0011, 1, 32'h200, 4'b0011, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[5]  = mk(0, 0, 32'h100, 1, 32'h200, WDATA, 4'b0011, 0, 0,       4'b0000, 0, 0,            1, 0,            0, 0, ARB_D_RESP);
    // I read of 0x200 sees the merged word
    vecs[6]  = mk(0, 1, 32'h200, 0, 32'h200, 0,     4'b0000, 1, 32'h200, 4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[7]  = mk(0, 1, 32'h200, 0, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 1, MERGED,       0, 0,            0, 0, ARB_I_RESP);
    // D read of 0x100
    vecs[8]  = mk(0, 0, 32'h100, 1, 32'h100, 0,     4'b0000, 1, 32'h100, 4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[9]  = mk(0, 0, 32'h100, 1, 32'h100, 0,     4'b0000, 0, 0,       4'b0000, 0, 0,            1, 32'hDEADBEEF, 1, 0, ARB_D_RESP);
    vecs[10] = mk(0, 0, 32'h100, 0, 32'h100, 0,     4'b0000, 0, 0,       4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    // contention: both continuously, grants D,I,D,I,D,I
    vecs[11] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h200, 4'b0000, 0, 0,            0, 0,            0, 0, ARB_IDLE);
    vecs[12] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h100, 4'b0000, 0, 0,            1, MERGED,       1, 1, ARB_D_RESP);
    vecs[13] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h200, 4'b0000, 1, 32'hDEADBEEF, 0, 0,            0, 1, ARB_I_RESP);
    vecs[14] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h100, 4'b0000, 0, 0,            1, MERGED,       1, 1, ARB_D_RESP);
    vecs[15] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h200, 4'b0000, 1, 32'hDEADBEEF, 0, 0,            0, 1, ARB_I_RESP);
    vecs[16] = mk(0, 1, 32'h100, 1, 32'h200, 0,     4'b0000, 1, 32'h100, 4'b0000, 0, 0,            1, MERGED,       1, 1, ARB_D_RESP);
    vecs[17] = mk(0, 1, 32'h100, 0, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 1, 32'hDEADBEEF, 0, 0,            0, 1, ARB_I_RESP);
    vecs[18] = mk(0, 0, 32'h100, 0, 32'h200, 0,     4'b0000, 0, 0,       4'b0000, 0, 0,            0, 0,            0, 1, ARB_IDLE);

    for (int n = 0; n < 19; n++) begin
      tick();
      rst = vecs[n].rst;
      i_req = vecs[n].i_req; i_addr = vecs[n].i_addr;
      d_req = vecs[n].d_req; d_addr = vecs[n].d_addr;
      d_wrdata = vecs[n].d_wrdata; d_wrstb = vecs[n].d_wrstb;
      settle();
      chk($sformatf("v%0d mem_en", n), 32'(mem_en), 32'(vecs[n].e_en));
      chk($sformatf("v%0d mem_wrstb", n), 32'(mem_wrstb), 32'(vecs[n].e_wrstb));
      chk($sformatf("v%0d i_ack", n), 32'(i_ack), 32'(vecs[n].e_iack));
      chk($sformatf("v%0d d_ack", n), 32'(d_ack), 32'(vecs[n].e_dack));
      chk($sformatf("v%0d conflict_cnt", n), 32'(conflict_cnt), 32'(vecs[n].e_cnt));
      chk($sformatf("v%0d state", n), 32'(state_dbg), 32'(vecs[n].e_state));
      if (vecs[n].e_en)
        chk($sformatf("v%0d mem_addr", n), mem_addr, vecs[n].e_addr);
      if (vecs[n].e_wrstb != 4'b0000)
        chk($sformatf("v%0d mem_wrdata", n), mem_wrdata, vecs[n].d_wrdata);
      if (vecs[n].e_iack)
        chk($sformatf("v%0d i_rddata", n), i_rddata, vecs[n].e_idata);
      if (vecs[n].e_dack && vecs[n].c_ddata)
        chk($sformatf("v%0d d_rddata", n), d_rddata, vecs[n].e_ddata);
    end

    // ---- reset landing on the response cycle of a D read ----
    tick();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b1; d_addr = 32'h100; d_wrstb = 4'b0000;
    settle();
    chk("rstmid grant mem_en", 32'(mem_en), 32'd1);
    chk("rstmid grant addr", mem_addr, 32'h100);
    tick();
    rst = 1'b1;
    settle();
    chk("rstmid d_ack", 32'(d_ack), 32'd0);
    chk("rstmid mem_en", 32'(mem_en), 32'd0);
    chk("rstmid i_ack", 32'(i_ack), 32'd0);
    tick();
    rst = 1'b0; d_req = 1'b0;
    settle();
    chk("rstmid after state", 32'(state_dbg), 32'(ARB_IDLE));
    chk("rstmid after mem_en", 32'(mem_en), 32'd0);
    chk("rstmid after d_ack", 32'(d_ack), 32'd0);
    chk("rstmid after cnt", 32'(conflict_cnt), 32'd0);

    // ---- saturation on the 2-bit counter: 5 IDLE ties ----
    for (int r = 1; r <= 5; r++) begin
      tick();
      i2_req = 1'b1; d2_req = 1'b1;          // IDLE tie, D granted
      settle();
      chk($sformatf("sat r%0d tie grant addr", r), mem2_addr, 32'h80);
      tick();
      i2_req = 1'b1; d2_req = 1'b0;          // D acked, I granted
      settle();
      chk($sformatf("sat r%0d cnt", r), 32'(conflict2_cnt), (r < 3) ? 32'(r) : 32'd3);
      chk($sformatf("sat r%0d d_ack", r), 32'(d2_ack), 32'd1);
      tick();
      i2_req = 1'b1; d2_req = 1'b0;          // I completing
      settle();
      chk($sformatf("sat r%0d i_ack", r), 32'(i2_ack), 32'd1);
      tick();
      i2_req = 1'b0; d2_req = 1'b0;          // back to IDLE
      settle();
    end
    chk("sat final cnt", 32'(conflict2_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
